// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART packet deframer.
//   state_e        : one-hot FSM encoding (HUNT, LEN, PAYLOAD, CHECK, EMIT)
//   STATE_RECOVER  : state taken from any illegal encoding
//   SYNC_DEFAULT   : default frame start byte
//   CHK_W          : width of the additive checksum
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [4:0] {
        ST_HUNT    = 5'b00001,
        ST_LEN     = 5'b00010,
        ST_PAYLOAD = 5'b00100,
        ST_CHECK   = 5'b01000,
        ST_EMIT    = 5'b10000
    } state_e;

    localparam state_e     STATE_RECOVER = ST_HUNT;
    localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
    localparam int         CHK_W         = 8;

endpackage

// File: rtl/uart_rx_packet_if.sv
// ---------------------------------------------------------------------------
// uart_rx_packet_if
// Verified-packet byte stream leaving the deframer.
//   data  : payload byte
//   valid : data is valid
//   last  : final payload byte of the packet
//   len   : length of the packet being emitted
//   ready : downstream accepts the byte
// master = deframer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_packet_if #(
    parameter int N = 8
);
    logic [N-1:0] data;
    logic         valid;
    logic         last;
    logic [7:0]   len;
    logic         ready;

    modport master (output data, output valid, output last, output len, input ready);
    modport slave  (input data, input valid, input last, input len, output ready);
endinterface

// File: rtl/uart_pkt_buf.sv
// ---------------------------------------------------------------------------
// uart_pkt_buf
// Payload store: DEPTH x N register file, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   sysclk  : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : combinational read data
// ---------------------------------------------------------------------------
module uart_pkt_buf #(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sysclk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [DEPTH];

    // Storage only; the buffered payload is don't-care after reset.
    always_ff @(posedge sysclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_packet.sv
// ---------------------------------------------------------------------------
// uart_rx_packet
// Deframes SYNC, LEN, payload, CHK from the UART byte receiver and replays
// only checksum-verified payloads on a valid/ready stream.
//   sysclk      : clock
//   reset       : synchronous, active-high
//   rx_data_i   : received byte, valid while rx_end_i is high
//   rx_end_i    : receiver level, rising edge = new byte
//   rx_err_i    : receiver level, rising edge = stop-bit error
//   pkt         : verified payload stream (master modport)
//   crc_err_o   : 1-cycle pulse on checksum mismatch
//   frame_err_o : 1-cycle pulse on illegal length or rx_err abort
//   timeout_o   : 1-cycle pulse on inter-byte timeout
//   drop_o      : 1-cycle pulse when a byte is discarded during EMIT
// ---------------------------------------------------------------------------
module uart_rx_packet
    import uart_pkg::*;
#(
    parameter int           N       = 8,
    parameter int           MAX_LEN = 16,
    parameter logic [N-1:0] SYNC    = N'(SYNC_DEFAULT),
    parameter int           TIMEOUT = 100000,
    parameter int           TO_W    = 17
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [N-1:0]             rx_data_i,
    input  logic                     rx_end_i,
    input  logic                     rx_err_i,
    uart_rx_packet_if.master         pkt,
    output logic                     crc_err_o,
    output logic                     frame_err_o,
    output logic                     timeout_o,
    output logic                     drop_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e             state_q, state_d;
    logic               rx_end_q, rx_err_q;
    logic [7:0]         len_q, len_d;
    logic [CHK_W-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d, rd_idx;
    logic [TO_W-1:0]    to_q, to_d;
    logic [N-1:0]       data_q, data_d;
    logic               valid_q, valid_d, last_q, last_d;
    logic               crc_q, crc_d, frm_q, frm_d, tmo_q, tmo_d, drop_q, drop_d;
    logic               buf_we;
    logic [N-1:0]       buf_rdata;
    logic               stb, estb, len_ok, at_timeout, idx_last;

    // Edge registers reset to 1 so a level already high out of reset is not a byte.
    assign stb        = rx_end_i & ~rx_end_q;
    assign estb       = rx_err_i & ~rx_err_q;
    assign len_ok     = (rx_data_i != '0) && (rx_data_i <= N'(MAX_LEN));
    assign at_timeout = (to_q == TO_W'(TIMEOUT - 1));
    assign idx_last   = (8'(idx_q) == len_q - 8'd1);

    uart_pkt_buf #(
        .N     (N),
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .sysclk  (sysclk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (rx_data_i),
        .raddr_i (rd_idx),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            rx_end_q <= 1'b1;
            rx_err_q <= 1'b1;
            len_q    <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            to_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            crc_q    <= 1'b0;
            frm_q    <= 1'b0;
            tmo_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_end_q <= rx_end_i;
            rx_err_q <= rx_err_i;
            len_q    <= len_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            crc_q    <= crc_d;
            frm_q    <= frm_d;
            tmo_q    <= tmo_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state logic. The output byte register is loaded from the buffer one
    // step ahead, so rd_idx points at the byte that becomes pkt.data next.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        to_d    = to_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        crc_d   = 1'b0;
        frm_d   = 1'b0;
        tmo_d   = 1'b0;
        drop_d  = 1'b0;
        buf_we  = 1'b0;
        rd_idx  = idx_q;

        case (state_q)
            ST_HUNT: begin
                if (stb && rx_data_i == SYNC) begin
                    state_d = ST_LEN;
                    to_d    = '0;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                // An error strobe beats a simultaneous byte strobe.
                if (estb) begin
                    frm_d   = 1'b1;
                    state_d = ST_HUNT;
                end else if (stb) begin
                    to_d = '0;
                    case (state_q)
                        ST_LEN: begin
                            if (len_ok) begin
                                len_d   = 8'(rx_data_i);
                                sum_d   = CHK_W'(rx_data_i);
                                idx_d   = '0;
                                state_d = ST_PAYLOAD;
                            end else begin
                                frm_d   = 1'b1;
                                state_d = ST_HUNT;
                            end
                        end
                        ST_PAYLOAD: begin
                            buf_we = 1'b1;
                            sum_d  = sum_q + CHK_W'(rx_data_i);
                            if (idx_last) begin
                                state_d = ST_CHECK;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                        ST_CHECK: begin
                            if (rx_data_i == N'(sum_q)) begin
                                idx_d   = '0;
                                rd_idx  = '0;
                                data_d  = buf_rdata;
                                valid_d = 1'b1;
                                last_d  = (len_q == 8'd1);
                                state_d = ST_EMIT;
                            end else begin
                                crc_d   = 1'b1;
                                state_d = ST_HUNT;
                            end
                        end
                        default: state_d = STATE_RECOVER;
                    endcase
                end else if (at_timeout) begin
                    tmo_d   = 1'b1;
                    state_d = ST_HUNT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            ST_EMIT: begin
                drop_d = stb;
                if (valid_q && pkt.ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_HUNT;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        rd_idx = idx_q + 1'b1;
                        data_d = buf_rdata;
                        last_d = (8'(idx_q) + 8'd1 == len_q - 8'd1);
                    end
                end
            end

            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = STATE_RECOVER;
            end
        endcase
    end

    assign pkt.data    = data_q;
    assign pkt.valid   = valid_q;
    assign pkt.last    = last_q;
    assign pkt.len     = len_q;
    assign crc_err_o   = crc_q;
    assign frame_err_o = frm_q;
    assign timeout_o   = tmo_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_uart_rx_packet.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_packet
// Self-checking bench for uart_rx_packet: a table of frames with their
// expected payloads and error pulses, randomized frames judged by a
// frame-level checksum model, and hand-written sequences for reset, stall,
// drop, timeout and rx_err aborts.
// ---------------------------------------------------------------------------
module tb_uart_rx_packet;

    localparam int N       = 8;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 20;
    localparam int TO_W    = 5;

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_end_i  = 1'b0;
    logic       rx_err_i  = 1'b0;
    logic       crc_err_o, frame_err_o, timeout_o, drop_o;

    uart_rx_packet_if #(.N(N)) pkt ();

    uart_rx_packet #(
        .N       (N),
        .MAX_LEN (MAX_LEN),
        .SYNC    (8'hA5),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .rx_data_i   (rx_data_i),
        .rx_end_i    (rx_end_i),
        .rx_err_i    (rx_err_i),
        .pkt         (pkt),
        .crc_err_o   (crc_err_o),
        .frame_err_o (frame_err_o),
        .timeout_o   (timeout_o),
        .drop_o      (drop_o)
    );

    always #5 sysclk = ~sysclk;

    // Monitor: logs every accepted byte and counts pulse cycles on the falling edge.
    logic [7:0] outData [0:4095];
    logic       outLast [0:4095];
    logic [7:0] outLen  [0:4095];
    int outCount = 0, crcCnt = 0, frameCnt = 0, toCnt = 0, dropCnt = 0;

    always @(negedge sysclk) begin
        if (pkt.valid && pkt.ready && outCount < 4096) begin
            outData[outCount] <= pkt.data;
            outLast[outCount] <= pkt.last;
            outLen[outCount]  <= pkt.len;
            outCount          <= outCount + 1;
        end
        if (crc_err_o)   crcCnt   <= crcCnt + 1;
        if (frame_err_o) frameCnt <= frameCnt + 1;
        if (timeout_o)   toCnt    <= toCnt + 1;
        if (drop_o)      dropCnt  <= dropCnt + 1;
    end

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  nBytes;
        logic [31:0] expData;
        logic [3:0]  expN;
        logic [3:0]  expCrc;
        logic [3:0]  expFrame;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] expBuf [16];
    int         tests = 0;
    int         failures = 0;

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One UART byte: rx_end_i high for two cycles, low for two.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data_i = b;
        rx_end_i  = 1'b1;
        tick();
        tick();
        rx_end_i  = 1'b0;
        tick();
        tick();
    endtask

    task automatic checkEmitted(input int base, input int expN, input int expLen);
        checkOutput("emit_count", 32'(outCount - base), 32'(expN));
        for (int i = 0; i < expN; i++) begin
            if (base + i < outCount) begin
                checkOutput("emit_data", 32'(outData[base + i]), 32'(expBuf[i]));
                checkOutput("emit_last", 32'(outLast[base + i]), 32'(i == expN - 1));
                checkOutput("emit_len",  32'(outLen[base + i]),  32'(expLen));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, c0, f0, t0, d0;
        int len, sum, chk, nJunk, junk;
        logic [7:0] pl;

        vecs[0] = '{64'hA503010203090000, 4'd6, 32'h01020300, 4'd3, 4'd0, 4'd0};
        vecs[1] = '{64'hA502102000000000, 4'd5, 32'h00000000, 4'd0, 4'd1, 4'd0};
        vecs[2] = '{64'hA502102032000000, 4'd5, 32'h10200000, 4'd2, 4'd0, 4'd0};
        vecs[3] = '{64'hA500000000000000, 4'd2, 32'h00000000, 4'd0, 4'd0, 4'd1};
        vecs[4] = '{64'hA511000000000000, 4'd2, 32'h00000000, 4'd0, 4'd0, 4'd1};
        vecs[5] = '{64'hA5017E7F00000000, 4'd4, 32'h7E000000, 4'd1, 4'd0, 4'd0};
        vecs[6] = '{64'h00A501FF00000000, 4'd5, 32'hFF000000, 4'd1, 4'd0, 4'd0};

        // Reset with rx_end_i already high carrying SYNC.
        pkt.ready = 1'b1;
        rx_data_i = 8'hA5;
        rx_end_i  = 1'b1;
        repeat (3) tick();
        checkOutput("reset_valid", 32'(pkt.valid), 32'd0);
        checkOutput("reset_last",  32'(pkt.last),  32'd0);
        checkOutput("reset_data",  32'(pkt.data),  32'd0);
        checkOutput("reset_len",   32'(pkt.len),   32'd0);
        checkOutput("reset_pulses", 32'({crc_err_o, frame_err_o, timeout_o, drop_o}), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        rx_end_i = 1'b0;
        tick();
        base = outCount;
        f0   = frameCnt;
        applyStimulus(8'h01);
        applyStimulus(8'h7E);
        applyStimulus(8'h7F);
        repeat (5) tick();
        checkOutput("held_end_not_counted", 32'(outCount - base), 32'd0);
        checkOutput("held_end_no_frame_err", 32'(frameCnt - f0), 32'd0);

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            base = outCount; c0 = crcCnt; f0 = frameCnt; t0 = toCnt; d0 = dropCnt;
            for (int i = 0; i < int'(vecs[v].nBytes); i++)
                applyStimulus(vecs[v].bytes[63 - 8*i -: 8]);
            repeat (10) tick();
            for (int i = 0; i < int'(vecs[v].expN); i++)
                expBuf[i] = vecs[v].expData[31 - 8*i -: 8];
            checkEmitted(base, int'(vecs[v].expN), int'(vecs[v].expN));
            checkOutput("vec_crc_err",   32'(crcCnt - c0),   32'(vecs[v].expCrc));
            checkOutput("vec_frame_err", 32'(frameCnt - f0), 32'(vecs[v].expFrame));
            checkOutput("vec_timeout",   32'(toCnt - t0),    32'd0);
            checkOutput("vec_drop",      32'(dropCnt - d0),  32'd0);
        end

        // Inter-byte timeout after A5 04 AA, then recovery.
        t0 = toCnt; f0 = frameCnt;
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'hAA);
        repeat (12) tick();
        checkOutput("timeout_not_early", 32'(toCnt - t0), 32'd0);
        repeat (10) tick();
        checkOutput("timeout_pulse", 32'(toCnt - t0), 32'd1);
        checkOutput("timeout_no_frame_err", 32'(frameCnt - f0), 32'd0);
        base = outCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h7E);
        applyStimulus(8'h7F);
        repeat (5) tick();
        expBuf[0] = 8'h7E;
        checkEmitted(base, 1, 1);

        // Stalled emit with a byte arriving meanwhile.
        pkt.ready = 1'b0;
        base = outCount; d0 = dropCnt;
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h35);
        checkOutput("stall_valid", 32'(pkt.valid), 32'd1);
        checkOutput("stall_data",  32'(pkt.data),  32'h11);
        checkOutput("stall_last",  32'(pkt.last),  32'd0);
        checkOutput("stall_len",   32'(pkt.len),   32'd2);
        applyStimulus(8'hA5);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_hold_data", 32'(pkt.data), 32'h11);
        end
        checkOutput("stall_drop", 32'(dropCnt - d0), 32'd1);
        pkt.ready = 1'b1;
        repeat (6) tick();
        expBuf[0] = 8'h11;
        expBuf[1] = 8'h22;
        checkEmitted(base, 2, 2);
        checkOutput("stall_idle_after", 32'(pkt.valid), 32'd0);

        // rx_err rise: ignored in HUNT, aborts in PAYLOAD.
        f0 = frameCnt;
        rx_err_i = 1'b1; tick(); tick(); rx_err_i = 1'b0; tick(); tick();
        checkOutput("err_in_hunt_ignored", 32'(frameCnt - f0), 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h01);
        rx_err_i = 1'b1; tick(); tick(); rx_err_i = 1'b0; tick(); tick();
        checkOutput("err_in_payload", 32'(frameCnt - f0), 32'd1);
        base = outCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h7E);
        applyStimulus(8'h7F);
        repeat (5) tick();
        expBuf[0] = 8'h7E;
        checkEmitted(base, 1, 1);

        // Reset in the middle of EMIT.
        pkt.ready = 1'b0;
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h55);
        applyStimulus(8'h56);
        checkOutput("pre_reset_valid", 32'(pkt.valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_emit_reset_valid", 32'(pkt.valid), 32'd0);
        checkOutput("mid_emit_reset_data",  32'(pkt.data),  32'd0);
        base = outCount;
        pkt.ready = 1'b1;
        repeat (5) tick();
        checkOutput("mid_emit_reset_no_emit", 32'(outCount - base), 32'd0);

        // Randomized frames judged by the frame-level checksum rule.
        for (int f = 0; f < 25; f++) begin
            nJunk = $urandom_range(0, 2);
            for (int j = 0; j < nJunk; j++) begin
                junk = $urandom_range(0, 255);
                if (junk == 'hA5) junk = 'h5A;
                applyStimulus(8'(junk));
            end
            base = outCount; c0 = crcCnt; f0 = frameCnt;
            len = $urandom_range(0, 18);
            applyStimulus(8'hA5);
            applyStimulus(8'(len));
            if (len == 0 || len > MAX_LEN) begin
                repeat (5) tick();
                checkEmitted(base, 0, 0);
                checkOutput("rand_frame_err", 32'(frameCnt - f0), 32'd1);
            end else begin
                sum = len;
                for (int i = 0; i < len; i++) begin
                    pl = 8'($urandom_range(0, 255));
                    expBuf[i] = pl;
                    sum += int'(pl);
                    applyStimulus(pl);
                end
                chk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : (sum % 256);
                applyStimulus(8'(chk));
                repeat (25) tick();
                if (chk == sum % 256) begin
                    checkEmitted(base, len, len);
                    checkOutput("rand_no_crc_err", 32'(crcCnt - c0), 32'd0);
                end else begin
                    checkEmitted(base, 0, len);
                    checkOutput("rand_crc_err", 32'(crcCnt - c0), 32'd1);
                end
                checkOutput("rand_no_frame_err", 32'(frameCnt - f0), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
